// File: rtl/ms_elastic_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ms_elastic_pipe : WIDTH x DEPTH valid/ready register pipeline, bubbles collapse
// Revision: 1.0
// ============================================================================
module ms_elastic_pipe #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             master_valid,
    output logic [WIDTH-1:0] master_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] w_adv;
    logic             w_accept;
    logic             w_pop;

    // Advance resolves from the slave stage back toward the master stage.
    always_comb begin
        w_adv          = '0;
        w_adv[DEPTH-1] = r_v[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = r_v[i] & (~r_v[i+1] | w_adv[i+1]);
        end
    end

    assign in_ready     = ~flush & (~r_v[0] | w_adv[0]);
    assign w_accept     = in_valid & in_ready;
    assign w_pop        = r_v[DEPTH-1] & out_ready;
    assign out_valid    = r_v[DEPTH-1];
    assign out_data     = r_d[DEPTH-1];
    assign master_valid = r_v[0];
    assign master_data  = r_d[0];
    assign count        = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v     <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else if (flush) begin
            // Data is left stale; only the valids and the count are cleared.
            r_v     <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_v[0] <= 1'b1;
                r_d[0] <= in_data;
            end else if (w_adv[0]) begin
                r_v[0] <= 1'b0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i-1]) begin
                    r_v[i] <= 1'b1;
                    r_d[i] <= r_d[i-1];
                end else if (w_adv[i]) begin
                    r_v[i] <= 1'b0;
                end
            end
            r_count <= r_count + CW'(w_accept) - CW'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ms_elastic_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for ms_elastic_pipe: word/position queue model plus directed literals.
module tb_ms_elastic_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic             master_valid;
    logic [WIDTH-1:0] master_data;
    logic [CW-1:0]    count;

    ms_elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .master_valid(master_valid), .master_data(master_data), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: words oldest-first with the stage index each one currently occupies.
    logic [WIDTH-1:0] mq[$];
    int               mp[$];
    bit               cur_iv, cur_ordy, cur_fl, exp_rdy;
    logic [WIDTH-1:0] cur_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each word moves one stage if the stage ahead is free after older words have moved.
    function automatic bit stage0_free_after(input bit ordy);
        int np[$];
        np = mp;
        if (np.size() > 0 && np[0] == DEPTH - 1 && ordy) void'(np.pop_front());
        for (int i = 0; i < np.size(); i++) begin
            int lim;
            lim = (i == 0) ? DEPTH - 1 : np[i-1] - 1;
            if (np[i] < lim) np[i] = np[i] + 1;
        end
        return (np.size() == 0) || (np[np.size()-1] > 0);
    endfunction

    task automatic drive(input bit iv, input logic [WIDTH-1:0] id, input bit ordy, input bit fl);
        bit ov_e, mv_e;
        @(negedge clk);
        in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
        cur_iv = iv; cur_id = id; cur_ordy = ordy; cur_fl = fl;
        #1;
        exp_rdy = !fl && stage0_free_after(ordy);
        ov_e = (mq.size() > 0) && (mp[0] == DEPTH - 1);
        mv_e = (mq.size() > 0) && (mp[mp.size()-1] == 0);
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(ov_e));
        if (ov_e) chk("out_data", 32'(out_data), 32'(mq[0]));
        chk("master_valid", 32'(master_valid), 32'(mv_e));
        if (mv_e) chk("master_data", 32'(master_data), 32'(mq[mq.size()-1]));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    endtask

    task automatic clk_edge();
        @(posedge clk);
        if (!rst || cur_fl) begin
            mq.delete();
            mp.delete();
        end else begin
            if (mq.size() > 0 && mp[0] == DEPTH - 1 && cur_ordy) begin
                void'(mq.pop_front());
                void'(mp.pop_front());
            end
            for (int i = 0; i < mp.size(); i++) begin
                int lim;
                lim = (i == 0) ? DEPTH - 1 : mp[i-1] - 1;
                if (mp[i] < lim) mp[i] = mp[i] + 1;
            end
            if (cur_iv && exp_rdy) begin
                mq.push_back(cur_id);
                mp.push_back(0);
            end
        end
    endtask

    task automatic step(input bit iv, input logic [WIDTH-1:0] id, input bit ordy, input bit fl);
        drive(iv, id, ordy, fl);
        clk_edge();
    endtask

    initial begin
        logic [WIDTH-1:0] got[$];
        int first_pop, last_pop;
        bit ordy_bias;

        // Reset state
        drive(0, 8'h00, 0, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_master_valid", 32'(master_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_master_data", 32'(master_data), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        clk_edge();
        #1 rst = 1'b1;

        // Latency on an empty pipe
        step(1, 8'hA5, 1, 0);
        repeat (3) step(0, 8'h00, 1, 0);
        drive(0, 8'h00, 0, 0);
        chk("lat_out_valid", 32'(out_valid), 1);
        chk("lat_out_data", 32'(out_data), 32'hA5);
        clk_edge();
        step(0, 8'h00, 1, 0);

        // Streaming, one word per cycle
        first_pop = -1; last_pop = -1;
        for (int k = 0; k < 22; k++) begin
            drive(k < 16, 8'(k + 1), 1, 0);
            if (out_valid) begin
                got.push_back(out_data);
                if (first_pop < 0) first_pop = k;
                last_pop = k;
            end
            clk_edge();
        end
        chk("stream_n", 32'(got.size()), 16);
        for (int j = 0; j < got.size() && j < 16; j++) chk("stream_word", 32'(got[j]), 32'(j + 1));
        chk("stream_rate", 32'(last_pop - first_pop), 15);

        // Backpressure fill
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        drive(1, 8'h99, 0, 0);
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_master", 32'(master_data), 32'h44);
        chk("full_out", 32'(out_data), 32'h11);
        clk_edge();
        drive(1, 8'h55, 1, 0);
        chk("fifth_rejected", 32'(master_data), 32'h44);
        chk("pushpop_in_ready", 32'(in_ready), 1);
        chk("pushpop_out", 32'(out_data), 32'h11);
        clk_edge();
        got.delete();
        for (int k = 0; k < 5; k++) begin
            drive(0, 8'h00, 1, 0);
            if (k == 0) begin
                chk("pushpop_count", 32'(count), 4);
                chk("pushpop_master", 32'(master_data), 32'h55);
            end
            if (out_valid) got.push_back(out_data);
            clk_edge();
        end
        chk("drain_n", 32'(got.size()), 4);
        if (got.size() == 4) begin
            chk("drain0", 32'(got[0]), 32'h22);
            chk("drain1", 32'(got[1]), 32'h33);
            chk("drain2", 32'(got[2]), 32'h44);
            chk("drain3", 32'(got[3]), 32'h55);
        end

        // Bubble collapse under backpressure
        step(1, 8'h66, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        step(1, 8'h77, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        drive(0, 8'h00, 0, 0);
        chk("bub_count", 32'(count), 2);
        chk("bub_in_ready", 32'(in_ready), 1);
        chk("bub_out", 32'(out_data), 32'h66);
        chk("bub_master_valid", 32'(master_valid), 0);
        clk_edge();

        // Flush drops the offered input
        step(1, 8'h88, 0, 0);
        drive(1, 8'h99, 0, 1);
        chk("flush_in_ready", 32'(in_ready), 0);
        clk_edge();
        drive(0, 8'h00, 0, 0);
        chk("flush_count", 32'(count), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_master_valid", 32'(master_valid), 0);
        clk_edge();

        // Asynchronous reset mid-stream
        step(1, 8'hC1, 0, 0);
        step(1, 8'hC2, 0, 0);
        step(1, 8'hC3, 0, 0);
        drive(0, 8'h00, 0, 0);
        chk("pre_rst_count", 32'(count), 3);
        #1 rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        mq.delete(); mp.delete();
        clk_edge();
        #1 rst = 1'b1;

        // Randomized traffic
        ordy_bias = 1'b1;
        for (int k = 0; k < 800; k++) begin
            if (k % 60 == 0) ordy_bias = $urandom_range(0, 1) != 0;
            step($urandom_range(0, 2) != 0, 8'($urandom),
                 ordy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 40) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
